// File: rtl/fetch_line_buffer_if.sv
// Bus, redirect and decode-side signals of the instruction fetch line buffer.
// master = fetch unit, slave = system bus / decode environment.
interface fetch_line_buffer_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
);
    logic                      bus_reqcyc;
    logic                      bus_reqack;
    logic [63:0]               bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_respcyc;
    logic                      bus_respack;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
    logic                      redirect_valid;
    logic [63:0]               redirect_pc;
    logic                      inst_valid;
    logic                      inst_ready;
    logic [31:0]               inst;
    logic [63:0]               inst_pc;

    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output inst_valid, inst, inst_pc,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        input  redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  inst_valid, inst, inst_pc,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        output redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_line_buffer.sv
// Instruction fetch line buffer: fetches 64-byte lines over the system bus and hands
// 32-bit instructions with their PC to decode. Optional feature: HALT_ON_ZERO_EN.
module fetch_line_buffer #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BYTES     = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [63:0]         entry,
    fetch_line_buffer_if.master fif,
    output logic                halted
);

    localparam int BEATS = LINE_BYTES * 8 / BUS_DATA_WIDTH;

    localparam logic       SYSBUS_READ   = 1'b1;
    localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;

    typedef enum logic [1:0] {
        REQ,
        RESP,
        DRAIN,
        HALT
    } state_t;

    state_t      state, state_next;
    logic [57:0] line_addr, line_addr_next;
    logic [3:0]  idx, idx_next;
    logic [2:0]  beat, beat_next;
    logic        discard, discard_next;
    logic        req_valid_q;
    logic [63:0] req_addr_q;

    logic [BUS_DATA_WIDTH-1:0] line_buf [BEATS];

    logic [31:0] cur_word;
    logic        req_fire;
    logic        beat_fire;
    logic        last_beat;
    logic        halt_zero;
    logic        inst_valid;
    logic        take_redirect;
    logic        unused_bits;

    assign cur_word  = idx[0] ? line_buf[idx[3:1]][63:32] : line_buf[idx[3:1]][31:0];
    assign req_fire  = (state == REQ) && req_valid_q && fif.bus_reqack;
    assign beat_fire = (state == RESP) && fif.bus_respcyc;
    assign last_beat = beat_fire && (beat == 3'(BEATS - 1));
    assign take_redirect = fif.redirect_valid && (state != HALT);

`ifdef HALT_ON_ZERO_EN
    assign halt_zero = (state == DRAIN) && (cur_word == 32'h0);
    assign halted    = (state == HALT);
`else
    assign halt_zero = 1'b0;
    assign halted    = 1'b0;
`endif

    assign inst_valid      = (state == DRAIN) && !halt_zero;
    assign fif.inst_valid  = inst_valid;
    assign fif.inst        = inst_valid ? cur_word : 32'h0;
    assign fif.inst_pc     = inst_valid ? {line_addr, idx, 2'b00} : 64'h0;
    assign fif.bus_respack = beat_fire;
    assign fif.bus_reqcyc  = req_valid_q;
    assign fif.bus_req     = req_addr_q;
    assign fif.bus_reqtag  = {SYSBUS_READ, SYSBUS_MEMORY, 8'h00};

    assign unused_bits = ^{entry[1:0], fif.redirect_pc[1:0], fif.bus_resptag};

    // Next-state logic; a redirect overrides whatever the current state would do,
    // except that beats of an already-acked line are still drained and discarded.
    always_comb begin
        state_next     = state;
        line_addr_next = line_addr;
        idx_next       = idx;
        beat_next      = beat;
        discard_next   = discard;

        case (state)
            REQ: begin
                if (req_fire) begin
                    state_next   = RESP;
                    beat_next    = 3'd0;
                    discard_next = 1'b0;
                end
            end
            RESP: begin
                if (beat_fire) begin
                    beat_next = beat + 3'd1;
                    if (last_beat) begin
                        state_next   = discard ? REQ : DRAIN;
                        discard_next = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (halt_zero) begin
                    state_next = HALT;
                end else if (fif.inst_ready) begin
                    if (idx == 4'd15) begin
                        line_addr_next = line_addr + 58'd1;
                        idx_next       = 4'd0;
                        state_next     = REQ;
                    end else begin
                        idx_next = idx + 4'd1;
                    end
                end
            end
            default: begin
                state_next = HALT;
            end
        endcase

        if (take_redirect) begin
            line_addr_next = fif.redirect_pc[63:6];
            idx_next       = fif.redirect_pc[5:2];
            case (state)
                REQ: begin
                    state_next   = req_fire ? RESP : REQ;
                    discard_next = req_fire;
                end
                RESP: begin
                    state_next   = last_beat ? REQ : RESP;
                    discard_next = !last_beat;
                end
                default: begin
                    state_next   = REQ;
                    discard_next = 1'b0;
                end
            endcase
        end
    end

    // The request address is loaded whenever the next state is REQ so that a redirect
    // arriving before the ack retargets the pending request on the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= REQ;
            line_addr   <= entry[63:6];
            idx         <= entry[5:2];
            beat        <= 3'd0;
            discard     <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= 64'h0;
        end else begin
            state       <= state_next;
            line_addr   <= line_addr_next;
            idx         <= idx_next;
            beat        <= beat_next;
            discard     <= discard_next;
            req_valid_q <= (state_next == REQ);
            if (state_next == REQ) begin
                req_addr_q <= {line_addr_next, 6'b000000};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beat_fire) begin
            line_buf[beat] <= fif.bus_resp;
        end
    end

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Directed testbench for fetch_line_buffer: bus responder, decode sink and
// hand-computed expectations (instruction word at address a is a[31:0]).
module tb_fetch_line_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] entry;
    logic        halted;

    int assertions = 0;
    int failures   = 0;

    fetch_line_buffer_if fif ();

    fetch_line_buffer dut (
        .clk    (clk),
        .reset  (reset),
        .entry  (entry),
        .fif    (fif),
        .halted (halted)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_reqcyc"}, 64'(fif.bus_reqcyc), 64'd0);
        checkOutput({tag, "_req"}, fif.bus_req, 64'd0);
        checkOutput({tag, "_respack"}, 64'(fif.bus_respack), 64'd0);
        checkOutput({tag, "_inst_valid"}, 64'(fif.inst_valid), 64'd0);
        checkOutput({tag, "_inst"}, 64'(fif.inst), 64'd0);
        checkOutput({tag, "_inst_pc"}, fif.inst_pc, 64'd0);
        checkOutput({tag, "_halted"}, 64'(halted), 64'd0);
    endtask

    task automatic do_reset(input logic [63:0] e);
        reset              = 1'b1;
        entry              = e;
        fif.bus_reqack     = 1'b0;
        fif.bus_respcyc    = 1'b0;
        fif.redirect_valid = 1'b0;
        fif.inst_ready     = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
    endtask

    task automatic serve_request(input logic [63:0] exp_addr, input int delay);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = fif.bus_reqcyc;
        end
        checkOutput("req_seen", 64'(seen), 64'd1);
        if (!seen) return;
        checkOutput("bus_req", fif.bus_req, exp_addr);
        checkOutput("bus_reqtag", 64'(fif.bus_reqtag), 64'h1100);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            checkOutput("req_hold_cyc", 64'(fif.bus_reqcyc), 64'd1);
            checkOutput("req_hold_addr", fif.bus_req, exp_addr);
        end
        fif.bus_reqack = 1'b1;
        @(negedge clk);
        fif.bus_reqack = 1'b0;
        checkOutput("req_drop", 64'(fif.bus_reqcyc), 64'd0);
    endtask

    // Sends the 8 beats of the line at base; optional idle gap before beat 4,
    // optional redirect alongside beat redirect_at, optional zeroed word.
    task automatic applyStimulus(input logic [63:0] base, input bit gap, input int redirect_at,
                                 input logic [63:0] rpc, input int zero_word);
        for (int b = 0; b < 8; b++) begin
            logic [31:0] lo;
            logic [31:0] hi;
            if (gap && b == 4) begin
                fif.bus_respcyc    = 1'b0;
                fif.redirect_valid = 1'b0;
                #1 checkOutput("respack_idle", 64'(fif.bus_respack), 64'd0);
                @(negedge clk);
            end
            lo = 32'(base + 64'(8 * b));
            hi = lo + 32'd4;
            if (zero_word == 2 * b) lo = 32'h0;
            if (zero_word == 2 * b + 1) hi = 32'h0;
            fif.bus_respcyc    = 1'b1;
            fif.bus_resp       = {hi, lo};
            fif.redirect_valid = (b == redirect_at);
            fif.redirect_pc    = rpc;
            #1 checkOutput("respack", 64'(fif.bus_respack), 64'd1);
            @(negedge clk);
        end
        fif.bus_respcyc    = 1'b0;
        fif.redirect_valid = 1'b0;
    endtask

    task automatic drain_line(input logic [63:0] first_pc, input int count, input bit stall,
                              input int zero_word, input bit check_end);
        for (int k = 0; k < count; k++) begin
            logic [63:0] p;
            logic [31:0] w;
            p = first_pc + 64'(4 * k);
            w = (int'(p[5:2]) == zero_word) ? 32'h0 : p[31:0];
            for (int t = 0; t < 20 && !fif.inst_valid; t++) @(negedge clk);
            checkOutput("inst_valid", 64'(fif.inst_valid), 64'd1);
            checkOutput("inst_pc", fif.inst_pc, p);
            checkOutput("inst", 64'(fif.inst), 64'(w));
            if (stall && (k % 2 == 1)) begin
                fif.inst_ready = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    checkOutput("stall_valid", 64'(fif.inst_valid), 64'd1);
                    checkOutput("stall_pc", fif.inst_pc, p);
                    checkOutput("stall_inst", 64'(fif.inst), 64'(w));
                end
            end
            fif.inst_ready = 1'b1;
            @(negedge clk);
        end
        if (check_end) checkOutput("valid_end", 64'(fif.inst_valid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        fif.bus_reqack     = 1'b0;
        fif.bus_respcyc    = 1'b0;
        fif.bus_resp       = 64'h0;
        fif.bus_resptag    = 13'h0;
        fif.redirect_valid = 1'b0;
        fif.redirect_pc    = 64'h0;
        fif.inst_ready     = 1'b0;
        reset              = 1'b1;
        entry              = 64'h0;

        $display("[TB] aligned entry 0x1000");
        do_reset(64'h1000);
        serve_request(64'h1000, 2);
        applyStimulus(64'h1000, 1'b0, -1, 64'h0, -1);
        checkOutput("valid_after_beat8", 64'(fif.inst_valid), 64'd1);
        drain_line(64'h1000, 16, 1'b0, -1, 1'b1);
        serve_request(64'h1040, 0);

        $display("[TB] reset during RESP with entry 0x3000");
        fif.bus_respcyc = 1'b1;
        fif.bus_resp    = 64'h0000_1044_0000_1040;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        entry = 64'h3000;
        @(negedge clk);
        check_reset_outputs("midresp");
        fif.bus_respcyc = 1'b0;
        reset = 1'b0;
        serve_request(64'h3000, 0);

        $display("[TB] unaligned entry 0x1028");
        do_reset(64'h1028);
        serve_request(64'h1000, 1);
        applyStimulus(64'h1000, 1'b0, -1, 64'h0, -1);
        drain_line(64'h1028, 6, 1'b0, -1, 1'b1);
        serve_request(64'h1040, 0);

        $display("[TB] decode stalls and beat gap");
        do_reset(64'h1000);
        serve_request(64'h1000, 0);
        applyStimulus(64'h1000, 1'b1, -1, 64'h0, -1);
        drain_line(64'h1000, 16, 1'b1, -1, 1'b1);
        serve_request(64'h1040, 0);

        $display("[TB] redirect during RESP");
        do_reset(64'h1000);
        serve_request(64'h1000, 0);
        applyStimulus(64'h1000, 1'b0, 3, 64'h2004, -1);
        checkOutput("redir_no_valid", 64'(fif.inst_valid), 64'd0);
        serve_request(64'h2000, 0);
        applyStimulus(64'h2000, 1'b0, -1, 64'h0, -1);
        drain_line(64'h2004, 15, 1'b0, -1, 1'b1);

        $display("[TB] back-to-back redirects in REQ, then redirect in DRAIN");
        do_reset(64'h1000);
        for (int i = 0; i < 50 && !fif.bus_reqcyc; i++) @(negedge clk);
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = 64'h6000;
        @(negedge clk);
        fif.redirect_pc    = 64'h5008;
        @(negedge clk);
        fif.redirect_valid = 1'b0;
        checkOutput("redir_req_cyc", 64'(fif.bus_reqcyc), 64'd1);
        checkOutput("redir_req_addr", fif.bus_req, 64'h5000);
        serve_request(64'h5000, 1);
        applyStimulus(64'h5000, 1'b0, -1, 64'h0, -1);
        drain_line(64'h5008, 3, 1'b0, -1, 1'b0);
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = 64'h1030;
        @(negedge clk);
        fif.redirect_valid = 1'b0;
        checkOutput("drain_redir_valid", 64'(fif.inst_valid), 64'd0);
        serve_request(64'h1000, 1);
        applyStimulus(64'h1000, 1'b0, -1, 64'h0, -1);
        drain_line(64'h1030, 4, 1'b0, -1, 1'b1);

        $display("[TB] zero word at index 5");
        do_reset(64'h1000);
        serve_request(64'h1000, 0);
        applyStimulus(64'h1000, 1'b0, -1, 64'h0, 5);
`ifdef HALT_ON_ZERO_EN
        begin
            bit any_req = 1'b0;
            drain_line(64'h1000, 5, 1'b0, 5, 1'b1);
            @(negedge clk);
            checkOutput("halted_set", 64'(halted), 64'd1);
            fif.redirect_valid = 1'b1;
            fif.redirect_pc    = 64'h2000;
            @(negedge clk);
            fif.redirect_valid = 1'b0;
            repeat (100) begin
                @(negedge clk);
                if (fif.bus_reqcyc || fif.inst_valid) any_req = 1'b1;
            end
            checkOutput("halt_quiet", 64'(any_req), 64'd0);
            checkOutput("halt_sticky", 64'(halted), 64'd1);
        end
`else
        drain_line(64'h1000, 16, 1'b0, 5, 1'b1);
        checkOutput("halted_tied", 64'(halted), 64'd0);
        serve_request(64'h1040, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
